// File: rtl/mem_swap_engine.sv
// rtl/mem_swap_engine.sv - register-array memory with swap/copy engine and host port
module mem_swap_engine #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        phase
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE,
        S_STORE,
        S_DONE
    } state_t;

    // One extra bit so DEPTH itself is representable when it is a power of two.
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   tmp_q;
    logic [ADDR_W-1:0]  addr_a_q, addr_a_d;
    logic [ADDR_W-1:0]  addr_b_q, addr_b_d;
    logic               mode_q, mode_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         phase_q, phase_d;

    logic a_ok, b_ok, wr_ok, rd_ok;
    logic start_ok, start_bad;

    assign a_ok      = {1'b0, addr_a}  < DEPTH_L;
    assign b_ok      = {1'b0, addr_b}  < DEPTH_L;
    assign wr_ok     = {1'b0, wr_addr} < DEPTH_L;
    assign rd_ok     = {1'b0, rd_addr} < DEPTH_L;
    assign start_ok  = start && a_ok && b_ok;
    assign start_bad = start && !(a_ok && b_ok);

    // Next-state, operand latching and registered status decode.
    always_comb begin
        state_d  = state_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        mode_d   = mode_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d  = S_LOAD;
                    addr_a_d = addr_a;
                    addr_b_d = addr_b;
                    mode_d   = mode;
                end
                err_d = start_bad;
            end
            S_LOAD:  state_d = mode_q ? S_STORE : S_MOVE;
            S_MOVE:  state_d = S_STORE;
            S_STORE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        done_d = (state_d == S_DONE);
        case (state_d)
            S_LOAD:  phase_d = 2'd1;
            S_MOVE:  phase_d = 2'd2;
            S_STORE: phase_d = 2'd3;
            default: phase_d = 2'd0;
        endcase
    end

    // Control registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            addr_a_q <= '0;
            addr_b_q <= '0;
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            phase_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            mode_q   <= mode_d;
            done_q   <= done_d;
            err_q    <= err_d;
            phase_q  <= phase_d;
        end
    end

    // Array and temp register: host writes only in IDLE, engine moves one word per state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            tmp_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (wr_en && wr_ok) begin
                        mem_q[wr_addr] <= wr_data;
                    end
                end
                S_LOAD:  tmp_q           <= mem_q[addr_a_q];
                S_MOVE:  mem_q[addr_a_q] <= mem_q[addr_b_q];
                S_STORE: mem_q[addr_b_q] <= tmp_q;
                default: ;
            endcase
        end
    end

    assign rd_data = rd_ok ? mem_q[rd_addr] : '0;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_mem_swap_engine.sv
// tb/tb_mem_swap_engine.sv - self-checking bench for mem_swap_engine
module tb_mem_swap_engine;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 10;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic              mode;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        phase;

    mem_swap_engine #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .mode    (mode),
        .addr_a  (addr_a),
        .addr_b  (addr_b),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .phase   (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              mode;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        logic [WIDTH-1:0]  da;
        logic [WIDTH-1:0]  db;
        logic [WIDTH-1:0]  ea;
        logic [WIDTH-1:0]  eb;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } sb_t;

    vec_t             vecs [6];
    sb_t              sbq [$];
    logic [WIDTH-1:0] model [DEPTH];
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < DEPTH) model[a] = d;
    endtask

    task automatic rd_chk(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] exp, input string name);
        rd_addr = a;
        #1;
        chk($sformatf("%s rd[%0d]", name, a), rd_data, exp);
    endtask

    task automatic check_all(input string name);
        for (int i = 0; i < DEPTH; i++) rd_chk(i[ADDR_W-1:0], model[i], name);
    endtask

    // Issues one operation and checks busy/phase/done/err on every cycle until IDLE.
    task automatic run_op(input logic m, input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input string name);
        int n;
        logic [1:0] ph;
        @(negedge clk);
        start = 1'b1; mode = m; addr_a = a; addr_b = b;
        @(negedge clk);
        start = 1'b0;
        n = m ? 3 : 4;
        for (int c = 1; c <= n + 1; c++) begin
            if (m) ph = (c == 1) ? 2'd1 : (c == 2) ? 2'd3 : 2'd0;
            else   ph = (c <= 3) ? c[1:0] : 2'd0;
            chk($sformatf("%s c%0d busy", name, c), busy, (c <= n) ? 1 : 0);
            chk($sformatf("%s c%0d phase", name, c), phase, ph);
            chk($sformatf("%s c%0d done", name, c), done, (c == n) ? 1 : 0);
            chk($sformatf("%s c%0d err", name, c), err, 0);
            if (c <= n) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        logic [WIDTH-1:0] t;
        sb_t e;

        vecs[0] = '{1'b0, 4'd3, 4'd9, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[1] = '{1'b1, 4'd2, 4'd5, 8'h11, 8'h77, 8'h11, 8'h11};
        vecs[2] = '{1'b0, 4'd4, 4'd4, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
        vecs[3] = '{1'b0, 4'd0, 4'd9, 8'h01, 8'hFE, 8'hFE, 8'h01};
        vecs[4] = '{1'b1, 4'd9, 4'd0, 8'hC7, 8'h00, 8'hC7, 8'hC7};
        vecs[5] = '{1'b1, 4'd7, 4'd7, 8'h80, 8'h80, 8'h80, 8'h80};

        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        reset_n = 1'b0; start = 1'b0; mode = 1'b0; addr_a = '0; addr_b = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset err", err, 0);
        chk("reset phase", phase, 0);
        check_all("reset");
        reset_n = 1'b1;

        // Table-driven swap/copy operations with scoreboarded results.
        for (int v = 0; v < 6; v++) begin
            wr(vecs[v].a, vecs[v].da);
            wr(vecs[v].b, vecs[v].db);
            sbq.push_back('{vecs[v].a, vecs[v].ea});
            sbq.push_back('{vecs[v].b, vecs[v].eb});
            run_op(vecs[v].mode, vecs[v].a, vecs[v].b, $sformatf("vec%0d", v));
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                rd_chk(e.addr, e.data, $sformatf("vec%0d sb", v));
                model[e.addr] = e.data;
            end
            check_all($sformatf("vec%0d all", v));
        end

        // Start and host write while busy are both ignored.
        wr(4'd0, 8'h42);
        @(negedge clk);
        start = 1'b1; mode = 1'b0; addr_a = 4'd3; addr_b = 4'd9;
        @(negedge clk);
        addr_a = 4'd0; addr_b = 4'd1;
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF;
        dones = 0;
        for (int c = 1; c <= 4; c++) begin
            if (done) dones++;
            chk($sformatf("coll c%0d err", c), err, 0);
            @(negedge clk);
        end
        start = 1'b0; wr_en = 1'b0;
        chk("coll idle busy", busy, 0);
        for (int c = 0; c < 3; c++) begin
            if (done) dones++;
            chk($sformatf("coll tail%0d busy", c), busy, 0);
            @(negedge clk);
        end
        chk("coll done count", dones, 1);
        t = model[3]; model[3] = model[9]; model[9] = t;
        check_all("coll");

        // Out-of-range operands raise a one-cycle err and leave memory alone.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; addr_a = 4'd12; addr_b = 4'd1;
        @(negedge clk);
        start = 1'b0;
        chk("rng1 err", err, 1);
        chk("rng1 busy", busy, 0);
        chk("rng1 done", done, 0);
        @(negedge clk);
        chk("rng1 err clear", err, 0);
        chk("rng1 busy after", busy, 0);
        start = 1'b1; mode = 1'b1; addr_a = 4'd1; addr_b = 4'd10;
        @(negedge clk);
        start = 1'b0;
        chk("rng2 err", err, 1);
        chk("rng2 busy", busy, 0);
        @(negedge clk);
        chk("rng2 err clear", err, 0);
        wr(4'd11, 8'hEE);
        rd_chk(4'd11, 8'h00, "rng");
        rd_chk(4'd15, 8'h00, "rng");
        check_all("rng");

        // Host write coinciding with start lands before LOAD reads it.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 4'd6; wr_data = 8'h99;
        start = 1'b1; mode = 1'b1; addr_a = 4'd6; addr_b = 4'd8;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("coin c%0d done", c), done, (c == 3) ? 1 : 0);
            if (c < 4) @(negedge clk);
        end
        model[6] = 8'h99; model[8] = 8'h99;
        check_all("coin");

        // Reset asserted during MOVE clears everything at once.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; addr_a = 4'd3; addr_b = 4'd9;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midrst pre phase", phase, 2);
        reset_n = 1'b0;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst phase", phase, 0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        check_all("midrst");
        @(negedge clk);
        reset_n = 1'b1;
        wr(4'd1, 8'hC3);
        wr(4'd2, 8'h3C);
        run_op(1'b0, 4'd1, 4'd2, "post");
        model[1] = 8'h3C; model[2] = 8'hC3;
        check_all("post");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_swap_engine.md
Name: mem_swap_engine

Overview:
- Parametrised successor to the 4-state memory swap controller.
- Owns a DEPTH x WIDTH register-array memory and a temp register.
- Executes swap (A<->B) or copy (A->B) between two arbitrary addresses on a start/busy/done handshake.
- A host read/write port gives direct array access while the engine is idle.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of words (>=2; need not be a power of 2)
ADDR_W, $clog2(DEPTH), address width

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request operation; sampled only in IDLE
mode  input  1  0 = swap A<->B, 1 = copy A->B; sampled with start
addr_a  input  ADDR_W  first operand address; sampled with start
addr_b  input  ADDR_W  second operand address; sampled with start
wr_en  input  1  host write strobe
wr_addr  input  ADDR_W  host write address
wr_data  input  WIDTH  host write data
rd_addr  input  ADDR_W  host read address
rd_data  output  WIDTH  combinational mem[rd_addr]; 0 if rd_addr >= DEPTH
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse at operation completion
err  output  1  one-cycle pulse when start is rejected
phase  output  2  0 = IDLE/DONE, 1 = LOAD, 2 = MOVE, 3 = STORE

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all memory words, tmp and latched addr/mode = 0.
  - busy=0, done=0, err=0, phase=0.
  - Reset mid-operation aborts immediately; the partial swap is discarded (array is cleared anyway).
- FSM states: IDLE, LOAD, MOVE, STORE, DONE.
- IDLE:
  - If start=1 and addr_a<DEPTH and addr_b<DEPTH: latch addr_a, addr_b, mode; go to LOAD.
  - If start=1 and either address >=DEPTH: err=1 for the next cycle (registered); stay IDLE; memory untouched.
- LOAD: tmp <= mem[a]. Next state is MOVE if mode=0, STORE if mode=1.
- MOVE (swap only): mem[a] <= mem[b]. Next state STORE.
- STORE: mem[b] <= tmp. Next state DONE.
- DONE: done=1 (registered, exactly one cycle); busy still 1. Next state IDLE.
- Timing (start sampled at edge 0):
  - Swap: LOAD in cycle 1, MOVE in cycle 2, STORE in cycle 3, done=1 in cycle 4, IDLE in cycle 5. busy is high for cycles 1..4.
  - Copy: LOAD in cycle 1, STORE in cycle 2, done in cycle 3. busy is high for cycles 1..3.
  - New start is accepted at the earliest in cycle 5 (swap) or cycle 4 (copy).
- Handshake:
  - start while busy=1 (including DONE) is ignored: no err, no queuing.
  - done and err never assert in the same cycle.
- Host write:
  - Applied at the clock edge only when state==IDLE, wr_en=1 and wr_addr<DEPTH.
  - Ignored silently while busy or when out of range.
  - If start and wr_en coincide in IDLE, the write lands first (same edge). LOAD in the next cycle reads the written value.
- Host read: rd_data is purely combinational from the array in all states. During an operation it shows intermediate contents.
- addr_a==addr_b: the operation runs the full normal sequence and timing; the word is unchanged at the end.
- phase: registered decode of state; 0 in IDLE and DONE.
- Array updates occur only at the single edge listed per state; no other word changes.

Test Plan:
- Reset then host-write mem[3]=0xA5 and mem[9]=0x3C; start mode=0 a=3 b=9 -> busy high for 4 cycles, phase sequence 1,2,3,0, done pulse in cycle 4; afterwards mem[3]=0x3C, mem[9]=0xA5, all other words still 0.
- Copy: mem[2]=0x11, mem[5]=0x77; start mode=1 a=2 b=5 -> phase sequence 1,3, done in cycle 3; mem[2]=0x11, mem[5]=0x11.
- Busy/collision: during a swap, pulse start (a=0,b=1) and wr_en (wr_addr=0, 0xFF) -> both ignored; mem[0] unchanged, exactly one done pulse.
- Range error with DEPTH=10: start with a=12, b=1 -> err=1 for one cycle, busy stays 0, memory unchanged. Also wr_addr=11 is ignored and rd_addr=11 returns 0.
- Same address: mem[4]=0x5A; swap a=b=4 -> normal 4-cycle timing, mem[4]=0x5A.
- Reset mid-op: assert reset_n=0 in the MOVE cycle -> busy/done/phase drop to 0 immediately, all rd_data reads 0, and a subsequent start works normally.
